// File: rtl/spi_if.sv
// Memory-bus port of the SPI master: one valid/ready request channel
// with a registered read-data response.
interface spi_if;
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;

    modport master (
        output valid, instr, addr, wdata, wstrb,
        input  rdata, ready
    );

    modport slave (
        input  valid, instr, addr, wdata, wstrb,
        output rdata, ready
    );
endinterface

// File: rtl/spi.sv
// SPI master peripheral, mode 0, MSB first, one byte per transfer.
// Chip-select is software driven; level interrupt on completion.
module spi #(
    parameter int clk_divider = 4
) (
    input  logic clk,
    input  logic rst,
    spi_if.slave bus,
    output logic spi_sclk,
    output logic spi_mosi,
    input  logic spi_miso,
    output logic spi_cs_n,
    output logic spi_irpt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEAD,
        S_TRAIL,
        S_FINISH
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(clk_divider - 1);

    state_t      state_q;
    logic [15:0] div_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic [7:0]  rx_q;
    logic        miso_q;
    logic        sclk_q;
    logic        cs_q;
    logic        ie_q;
    logic        done_q;
    logic        ready_q;
    logic [31:0] rdata_q;

    logic        acc_d;
    logic        wr_d;
    logic        rd_d;
    logic [2:0]  sel_d;
    logic        busy_d;
    logic [31:0] rdata_d;

    // Decode the bus request and select the read value.
    always_comb begin
        acc_d   = bus.valid & ~ready_q;
        wr_d    = acc_d & bus.wstrb[0];
        rd_d    = acc_d & ~(|bus.wstrb);
        sel_d   = bus.addr[4:2];
        busy_d  = (state_q != S_IDLE);
        rdata_d = '0;
        if (rd_d) begin
            case (sel_d)
                3'd0:    rdata_d = {30'b0, ie_q, cs_q};
                3'd1:    rdata_d = {30'b0, done_q, busy_d};
                3'd3:    rdata_d = {24'b0, rx_q};
                default: rdata_d = '0;
            endcase
        end
    end

    // Bus response, control registers and the shift FSM; FSM
    // assignments come last so a completing transfer's done-set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            rx_q    <= '0;
            miso_q  <= 1'b0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b0;
            ie_q    <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= acc_d;
            rdata_q <= rdata_d;

            if (wr_d && sel_d == 3'd0) begin
                cs_q <= bus.wdata[0];
                ie_q <= bus.wdata[1];
            end
            if (wr_d && sel_d == 3'd1 && bus.wdata[1])
                done_q <= 1'b0;
            if (rd_d && sel_d == 3'd3)
                done_q <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (wr_d && sel_d == 3'd2) begin
                        shift_q <= bus.wdata[7:0];
                        done_q  <= 1'b0;
                        bit_q   <= '0;
                        div_q   <= '0;
                        state_q <= S_LEAD;
                    end
                end
                S_LEAD: begin
                    if (div_q == DIV_LAST) begin
                        sclk_q  <= 1'b1;
                        miso_q  <= spi_miso;
                        div_q   <= '0;
                        state_q <= S_TRAIL;
                    end else begin
                        div_q <= div_q + 16'd1;
                    end
                end
                S_TRAIL: begin
                    if (div_q == DIV_LAST) begin
                        sclk_q  <= 1'b0;
                        shift_q <= {shift_q[6:0], miso_q};
                        bit_q   <= bit_q + 3'd1;
                        div_q   <= '0;
                        state_q <= (bit_q == 3'd7) ? S_FINISH : S_LEAD;
                    end else begin
                        div_q <= div_q + 16'd1;
                    end
                end
                S_FINISH: begin
                    rx_q    <= shift_q;
                    done_q  <= 1'b1;
                    div_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.rdata = rdata_q;
    assign spi_sclk  = sclk_q;
    assign spi_mosi  = shift_q[7];
    assign spi_cs_n  = ~cs_q;
    assign spi_irpt  = done_q & ie_q;

    logic unused_ok;
    assign unused_ok = ^{bus.instr, bus.addr[31:5], bus.addr[1:0],
                         bus.wdata[31:8]};

endmodule

// File: doc/spi.md
# spi

Memory-mapped SPI master peripheral on the CPU memory bus, a sibling of the bram, uart and timer slaves behind the top-level address decoder. It accepts word accesses on the valid/ready bus, shifts one byte at a time in SPI mode 0 (CPOL=0, CPHA=0), MSB first, and raises a level interrupt when a transfer completes. Chip-select is software controlled.

## Interface
- clk_divider, default 4: sclk half-period in clk cycles; legal range 1..65535.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- spi_valid  in  1  bus request, routed by the top-level address decoder.
- spi_instr  in  1  instruction-fetch flag; ignored, a fetch is treated as a read.
- spi_addr  in  32  byte address; only addr[4:2] decoded.
- spi_wdata  in  32  write data.
- spi_wstrb  in  4  byte strobes; nonzero = write, zero = read.
- spi_rdata  out  32  read data, valid while spi_ready=1.
- spi_ready  out  1  one-cycle response pulse.
- spi_sclk  out  1  SPI clock, idles low.
- spi_mosi  out  1  master-out data.
- spi_miso  in  1  master-in data, externally synchronous to spi_sclk.
- spi_cs_n  out  1  chip select, active-low.
- spi_irpt  out  1  interrupt, level.

## Operation
- Register map (addr[4:2]):
  - 0 CTRL rw: bit0 cs (1 drives spi_cs_n low), bit1 ie (interrupt enable).
  - 1 STATUS: bit0 busy (read-only), bit1 done (write 1 clears).
  - 2 TXDATA w: bits[7:0]; a write while idle starts a transfer. A write while busy is dropped, no error.
  - 3 RXDATA r: bits[7:0] of the last received byte; a read clears done.
  - 4..7: reads return 0, writes ignored.
- Writes apply when wstrb[0]=1. Bits above those defined read as 0.
- Bus: spi_valid=1 is sampled at a clk edge. spi_ready=1 and spi_rdata follow on the next edge for exactly one cycle. No back-to-back acceptance: spi_valid is not sampled in the cycle spi_ready=1. Writes return rdata=0.
- FSM states:
  - IDLE: sclk=0, mosi=tx[7]. A TXDATA write loads the shift register, clears done, and moves to LEAD.
  - LEAD: after clk_divider cycles, sclk rises, miso is sampled into rx LSB, and the FSM moves to TRAIL.
  - TRAIL: after clk_divider cycles, sclk falls and the shift register shifts left (mosi = next bit). The bit counter increments; after 8 bits the FSM goes to FINISH, otherwise back to LEAD.
  - FINISH: for one cycle, RXDATA is copied from the shift register, done=1, and the FSM returns to IDLE.
- busy = (state != IDLE).
- spi_irpt = done & ie, combinational from registers.
- spi_cs_n = ~cs, independent of the FSM. Software changing cs mid-transfer does not stop the shift.
- Divider counter is 16 bits and resets to 0 on every state change.

## Timing
- Reset values:
  - spi_rdata=0, spi_ready=0, spi_sclk=0, spi_mosi=0, spi_cs_n=1, spi_irpt=0.
  - CTRL=0, done=0, RXDATA=0, state=IDLE.
- Write to TXDATA accepted at edge T: the FSM is in LEAD from T+1. The first sclk rise is at T+1+clk_divider.
- Full byte: busy for 16*clk_divider+1 cycles. done is seen in STATUS from the cycle after FINISH.
- Simultaneous FINISH and a RXDATA read: the read returns the old RXDATA, done ends at 1 (set wins).
- Simultaneous FINISH and a STATUS write of 1 to bit1: done ends at 1 (set wins).
- Reset asserted mid-transfer: all state returns to reset values immediately. sclk drops low asynchronously and the partial byte is discarded.

## Test plan
- Reset: hold rst=1 with spi_miso=1 → all outputs at reset values. Read STATUS after release → rdata=0, ready exactly one cycle after valid.
- Loopback, clk_divider=2: write CTRL=1, then TXDATA=0xA5 with mosi tied to miso.
  - spi_cs_n=0; 8 sclk pulses of 2-high/2-low cycles.
  - STATUS reads 0x1 during the transfer, 0x2 after it; RXDATA=0xA5, then done reads 0.
- Slave model returns 0x3C, ie=1: spi_irpt rises one cycle after FINISH. Writing STATUS=0x2 drops spi_irpt next cycle.
- Write TXDATA=0xFF while busy with 0x12 in flight → MOSI carries only 0x12; RXDATA is unaffected by the 0xFF.
- Assert rst after the 4th sclk rise → sclk=0 and cs_n=1 in the same cycle. A new 0x81 transfer after reset completes with RXDATA correct.
- Reads of offsets 0x14 and 0x1C return 0; a write with wstrb=0 to TXDATA starts no transfer.
